// File: rtl/ai_density_engine.sv
// Hunt-mode density engine: sweeps every legal placement of each alive ship on
// a 10x10 board, accumulates per-cell coverage, then picks the densest unfired cell.
module ai_density_engine #(
    parameter int         CNT_W   = 8,
    parameter logic [6:0] INV_IDX = 7'd127
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [99:0]      fired,
    input  logic [4:0]       ships,
    output logic             done,
    input  logic [6:0]       rd_index,
    output logic [CNT_W-1:0] rd_density,
    output logic [6:0]       largest_index,
    output logic [CNT_W-1:0] largest_value
);

    typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_SWEEP, ST_SCAN} state_t;

    state_t           r_state;
    logic             r_done;
    logic [99:0]      r_fired;
    logic [4:0]       r_ships;
    logic [2:0]       r_ship;
    logic             r_orient;     // 0 = horizontal, 1 = vertical
    logic [3:0]       r_row;
    logic [3:0]       r_col;
    logic [6:0]       r_scan_idx;
    logic             r_found;
    logic [6:0]       r_best_idx;
    logic [CNT_W-1:0] r_best_val;
    logic [6:0]       r_largest_index;
    logic [CNT_W-1:0] r_largest_value;
    logic [CNT_W-1:0] r_cnt [100];

    logic [2:0]       w_len;
    logic [6:0]       w_base;
    logic [7:0]       w_idx;
    logic             w_in_bounds;
    logic [99:0]      w_cover;
    logic             w_valid;
    logic [3:0]       w_first;
    logic [3:0]       w_next;
    logic [CNT_W-1:0] w_scan_cnt;
    logic             w_take;

    function automatic logic [2:0] ship_len(input logic [2:0] s);
        case (s)
            3'd0:    return 3'd2;
            3'd1:    return 3'd3;
            3'd2:    return 3'd3;
            3'd3:    return 3'd4;
            default: return 3'd5;
        endcase
    endfunction

    // Returns {found, index} of the lowest set bit of mask at position >= lo.
    function automatic logic [3:0] first_from(input logic [4:0] mask, input int lo);
        logic [3:0] res;
        res = 4'd0;
        for (int i = 4; i >= 0; i--) begin
            if (mask[i] && i >= lo) res = {1'b1, 3'(i)};
        end
        return res;
    endfunction

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_len       = ship_len(r_ship);
        w_base      = 7'(r_row) * 7'd10 + 7'(r_col);
        w_in_bounds = r_orient ? ({1'b0, r_row} + {2'b00, w_len} <= 5'd10)
                               : ({1'b0, r_col} + {2'b00, w_len} <= 5'd10);
        w_cover     = '0;
        w_idx       = '0;
        for (int k = 0; k < 5; k++) begin
            if (3'(k) < w_len) begin
                w_idx = r_orient ? ({1'b0, w_base} + 8'(10 * k)) : ({1'b0, w_base} + 8'(k));
                if (w_in_bounds) w_cover[w_idx] = 1'b1;
            end
        end
        w_valid = w_in_bounds && ((w_cover & r_fired) == '0);
    end

    assign w_first    = first_from(r_ships, 0);
    assign w_next     = first_from(r_ships, int'(r_ship) + 1);
    assign w_scan_cnt = r_cnt[r_scan_idx];
    assign w_take     = !r_fired[r_scan_idx] && (!r_found || (w_scan_cnt > r_best_val));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_done          <= 1'b1;
            r_fired         <= '0;
            r_ships         <= '0;
            r_ship          <= '0;
            r_orient        <= 1'b0;
            r_row           <= '0;
            r_col           <= '0;
            r_scan_idx      <= '0;
            r_found         <= 1'b0;
            r_best_idx      <= '0;
            r_best_val      <= '0;
            r_largest_index <= '0;
            r_largest_value <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_fired <= fired;
                        r_ships <= ships;
                        r_done  <= 1'b0;
                        r_state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    r_ship     <= w_first[2:0];
                    r_orient   <= 1'b0;
                    r_row      <= '0;
                    r_col      <= '0;
                    r_scan_idx <= '0;
                    r_found    <= 1'b0;
                    r_best_idx <= '0;
                    r_best_val <= '0;
                    r_state    <= w_first[3] ? ST_SWEEP : ST_SCAN;
                end
                ST_SWEEP: begin
                    if (r_col == 4'd9) begin
                        r_col <= '0;
                        if (r_row == 4'd9) begin
                            r_row <= '0;
                            if (r_orient) begin
                                r_orient <= 1'b0;
                                if (w_next[3]) r_ship <= w_next[2:0];
                                else           r_state <= ST_SCAN;
                            end else begin
                                r_orient <= 1'b1;
                            end
                        end else begin
                            r_row <= r_row + 4'd1;
                        end
                    end else begin
                        r_col <= r_col + 4'd1;
                    end
                end
                ST_SCAN: begin
                    if (w_take) begin
                        r_found    <= 1'b1;
                        r_best_idx <= r_scan_idx;
                        r_best_val <= w_scan_cnt;
                    end
                    if (r_scan_idx == 7'd99) begin
                        // The last cell's decision is folded in here rather than a cycle later.
                        if (w_take) begin
                            r_largest_index <= r_scan_idx;
                            r_largest_value <= w_scan_cnt;
                        end else if (r_found) begin
                            r_largest_index <= r_best_idx;
                            r_largest_value <= r_best_val;
                        end else begin
                            r_largest_index <= INV_IDX;
                            r_largest_value <= '0;
                        end
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_scan_idx <= r_scan_idx + 7'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the counter array is reset because readback must show zeros right after reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 100; i++) r_cnt[i] <= '0;
        end else if (r_state == ST_CLEAR) begin
            for (int i = 0; i < 100; i++) r_cnt[i] <= '0;
        end else if (r_state == ST_SWEEP && w_valid) begin
            for (int i = 0; i < 100; i++) begin
                if (w_cover[i]) r_cnt[i] <= r_cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        rd_density = '0;
        if (rd_index < 7'd100) rd_density = r_cnt[rd_index];
    end

    assign done          = r_done;
    assign largest_index = r_largest_index;
    assign largest_value = r_largest_value;

endmodule

// File: tb/tb_ai_density_engine.sv
// Directed bench for ai_density_engine: latency, densities and target selection
// against hand-computed values for the empty board, single ship and edge cases.
module tb_ai_density_engine;

    localparam int CNT_W  = 8;
    localparam int BUDGET = 3000;

    logic             clock   = 1'b0;
    logic             reset_n = 1'b1;
    logic             start   = 1'b0;
    logic [99:0]      fired   = '0;
    logic [4:0]       ships   = '0;
    logic             done;
    logic [6:0]       rd_index = '0;
    logic [CNT_W-1:0] rd_density;
    logic [6:0]       largest_index;
    logic [CNT_W-1:0] largest_value;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    ai_density_engine #(.CNT_W(CNT_W), .INV_IDX(7'd127)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .fired         (fired),
        .ships         (ships),
        .done          (done),
        .rd_index      (rd_index),
        .rd_density    (rd_density),
        .largest_index (largest_index),
        .largest_value (largest_value)
    );

    // Leaves time at 1 ns after the edge that samples start.
    task automatic launch(input logic [99:0] f, input logic [4:0] s);
        @(posedge clock); #1;
        fired = f;
        ships = s;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // Counts edges after the start-sampling edge until done is seen high.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < BUDGET) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic read_density(input int idx, output logic [CNT_W-1:0] v);
        rd_index = 7'(idx);
        #1;
        v = rd_density;
    endtask

    task automatic test_reset;
        logic [CNT_W-1:0] d;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL reset_done: got %0b expected 1", done);
        end
        checks++;
        if (largest_index !== 7'd0 || largest_value !== '0) begin
            errors++; $display("FAIL reset_largest: got %0d/%0d expected 0/0", largest_index, largest_value);
        end
        read_density(44, d);
        checks++;
        if (d !== '0) begin
            errors++; $display("FAIL reset_density: got %0d expected 0", d);
        end
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    task automatic check_full_board(input string tag, input int lat);
        logic [CNT_W-1:0] d;
        checks++;
        if (lat !== 1101) begin
            errors++; $display("FAIL %s_latency: got %0d expected 1101", tag, lat);
        end
        read_density(0, d);
        checks++;
        if (d !== 8'd10) begin
            errors++; $display("FAIL %s_density0: got %0d expected 10", tag, d);
        end
        read_density(44, d);
        checks++;
        if (d !== 8'd34) begin
            errors++; $display("FAIL %s_density44: got %0d expected 34", tag, d);
        end
        read_density(9, d);
        checks++;
        if (d !== 8'd10) begin
            errors++; $display("FAIL %s_density9: got %0d expected 10", tag, d);
        end
        checks++;
        if (largest_index !== 7'd44 || largest_value !== 8'd34) begin
            errors++; $display("FAIL %s_largest: got %0d/%0d expected 44/34", tag, largest_index, largest_value);
        end
    endtask

    task automatic test_empty_board;
        int lat;
        logic [CNT_W-1:0] d;
        launch('0, 5'h1F);
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL empty_busy: got done=%0b expected 0", done);
        end
        wait_done(lat);
        check_full_board("empty", lat);
        read_density(100, d);
        checks++;
        if (d !== '0) begin
            errors++; $display("FAIL rd_out_of_range: got %0d expected 0", d);
        end
    endtask

    task automatic test_single_ship;
        int lat;
        logic [CNT_W-1:0] d;
        launch('0, 5'b00001);
        repeat (150) @(posedge clock);
        #1;
        checks++;
        if (largest_index !== 7'd44 || largest_value !== 8'd34) begin
            errors++; $display("FAIL hold_largest: got %0d/%0d expected 44/34", largest_index, largest_value);
        end
        wait_done(lat);
        lat += 150;
        checks++;
        if (lat !== 301) begin
            errors++; $display("FAIL single_latency: got %0d expected 301", lat);
        end
        read_density(0, d);
        checks++;
        if (d !== 8'd2) begin
            errors++; $display("FAIL single_density0: got %0d expected 2", d);
        end
        read_density(1, d);
        checks++;
        if (d !== 8'd3) begin
            errors++; $display("FAIL single_density1: got %0d expected 3", d);
        end
        read_density(44, d);
        checks++;
        if (d !== 8'd4) begin
            errors++; $display("FAIL single_density44: got %0d expected 4", d);
        end
        checks++;
        if (largest_index !== 7'd11 || largest_value !== 8'd4) begin
            errors++; $display("FAIL single_largest: got %0d/%0d expected 11/4", largest_index, largest_value);
        end
    endtask

    task automatic test_blocked_cell;
        int lat;
        logic [99:0] f;
        logic [CNT_W-1:0] d;
        f = '0;
        f[44] = 1'b1;
        launch(f, 5'b10000);
        wait_done(lat);
        checks++;
        if (lat !== 301) begin
            errors++; $display("FAIL blocked_latency: got %0d expected 301", lat);
        end
        read_density(44, d);
        checks++;
        if (d !== '0) begin
            errors++; $display("FAIL blocked_density44: got %0d expected 0", d);
        end
        read_density(43, d);
        checks++;
        if (d !== 8'd5) begin
            errors++; $display("FAIL blocked_density43: got %0d expected 5", d);
        end
    endtask

    task automatic test_boundary;
        int lat;
        int nonzero;
        logic [99:0] f;
        logic [CNT_W-1:0] d;
        f = '0;
        f[0] = 1'b1;
        launch(f, 5'b00000);
        wait_done(lat);
        checks++;
        if (lat !== 101) begin
            errors++; $display("FAIL noships_latency: got %0d expected 101", lat);
        end
        nonzero = 0;
        for (int i = 0; i < 100; i++) begin
            read_density(i, d);
            if (d !== '0) nonzero++;
        end
        checks++;
        if (nonzero !== 0) begin
            errors++; $display("FAIL noships_densities: got %0d nonzero cells expected 0", nonzero);
        end
        checks++;
        if (largest_index !== 7'd1 || largest_value !== '0) begin
            errors++; $display("FAIL noships_largest: got %0d/%0d expected 1/0", largest_index, largest_value);
        end

        launch('1, 5'h1F);
        wait_done(lat);
        checks++;
        if (lat !== 1101) begin
            errors++; $display("FAIL allfired_latency: got %0d expected 1101", lat);
        end
        checks++;
        if (largest_index !== 7'd127 || largest_value !== '0) begin
            errors++; $display("FAIL allfired_largest: got %0d/%0d expected 127/0", largest_index, largest_value);
        end
    endtask

    task automatic test_start_while_busy;
        int lat;
        launch('0, 5'h1F);
        lat = 0;
        while (!done && lat < BUDGET) begin
            @(posedge clock); #1;
            lat++;
            if (lat == 50) start = 1'b1;
            if (lat == 51) start = 1'b0;
            if (lat == 60) begin
                fired = '1;
                ships = 5'b00000;
            end
        end
        check_full_board("busy_start", lat);
        fired = '0;
        ships = 5'h1F;
    endtask

    task automatic test_reset_mid_sweep;
        int lat;
        logic [CNT_W-1:0] d;
        launch('0, 5'h1F);
        repeat (300) @(posedge clock);
        #2;
        read_density(44, d);
        checks++;
        if (d !== 8'd7 || done !== 1'b0) begin
            errors++; $display("FAIL partial_density44: got %0d done=%0b expected 7 done=0", d, done);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (done !== 1'b1 || largest_index !== 7'd0 || largest_value !== '0) begin
            errors++; $display("FAIL midreset_outputs: got done=%0b %0d/%0d expected 1 0/0",
                               done, largest_index, largest_value);
        end
        checks++;
        if (rd_density !== '0) begin
            errors++; $display("FAIL midreset_density44: got %0d expected 0", rd_density);
        end
        @(negedge clock);
        reset_n = 1'b1;
        launch('0, 5'h1F);
        wait_done(lat);
        check_full_board("after_reset", lat);
    endtask

    initial begin
        test_reset();
        test_empty_board();
        test_single_ship();
        test_blocked_cell();
        test_boundary();
        test_start_while_busy();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ai_density_engine.md
Name: ai_density_engine

Overview:
- Hunt-mode probability core that sits directly downstream of the Avalon register front end of `ai`.
- The front end latches the fired-cell mask and the alive-ship mask from the HPS, then pulses `start`.
- This block sweeps every legal placement of every alive ship on the 10x10 board and accumulates a per-cell density.
- It then scans for the highest-density unfired cell and returns that cell as the next shot.

Parameters:
- CNT_W, 8, width of each per-cell density counter; must be at least 6, since the maximum legal count is 34.
- INV_IDX, 127, value of `largest_index` when no unfired cell exists.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request a new computation; sampled only in IDLE.
- fired  input  100  bit i=1 means cell i has already been shot; i = row*10 + col.
- ships  input  5  alive mask; bit0=len2, bit1=len3, bit2=len3, bit3=len4, bit4=len5.
- done  output  1  high when idle with valid results; low while busy.
- rd_index  input  7  cell select for density readback.
- rd_density  output  CNT_W  density of cell rd_index; 0 if rd_index >= 100.
- largest_index  output  7  chosen target cell.
- largest_value  output  CNT_W  density of the chosen target cell.

Behaviour:
- Reset (asynchronous): state=IDLE, done=1, all 100 counters=0, largest_index=0, largest_value=0.
- IDLE, start=1: latch `fired` and `ships`, drop done on that same edge, go to CLEAR. start while not IDLE is ignored.
- CLEAR (1 cycle):
  - zero all counters;
  - set the ship pointer to the lowest alive ship;
  - go to SWEEP, or go to SCAN if the latched ships mask is 0.
- SWEEP: one placement per cycle, order ship (ascending bit) -> orientation (H then V) -> row 0..9 -> col 0..9. That is 200 cycles per alive ship; dead ships are skipped with zero cycles.
- Placement validity:
  - H placement at (r,c), length L: valid iff c+L <= 10 and none of cells r*10+c .. r*10+c+L-1 is fired.
  - V placement: valid iff r+L <= 10 and none of cells (r+k)*10+c, k=0..L-1, is fired.
  - A valid placement increments all L covered counters in the same cycle. The cells are distinct, so there is no conflict.
- Counters cannot overflow at CNT_W >= 6; no saturation logic is required.
- After the last placement of the last alive ship, go to SCAN.
- SCAN (100 cycles):
  - Visit cells 0..99, one per cycle.
  - Track the best unfired cell using strict '>' comparison, so ties resolve to the lowest index.
  - The tracker is initialised "empty"; the first unfired cell is always taken, even when its density is 0.
- SCAN exit:
  - Write largest_index and largest_value, raise done, return to IDLE.
  - If no unfired cell was found: largest_index=INV_IDX, largest_value=0.
- largest_index and largest_value hold their previous values until SCAN completes.
- Latency: done rises exactly 1 + 200*k + 100 cycles after the edge that sampled start, where k = popcount(ships).
- rd_density is combinational from the counter array. It is valid for the finished result only while done=1; during SWEEP it shows partial counts.
- Fired cells are never covered by a valid placement, so their density is always 0.
- Reset mid-operation: immediate return to the reset state; the partial result is discarded.
- Changing `fired` or `ships` while busy has no effect, because both are latched.

Test Plan:
1. Empty board:
   - Stimulus: fired=0, ships=5'h1F.
   - Required: done after 1101 cycles; density[0]=10, density[44]=34, density[9]=10; largest_index=44, largest_value=34.
2. Single len2 ship:
   - Stimulus: fired=0, ships=5'b00001.
   - Required: done after 301 cycles; density[0]=2, density[1]=3, density[44]=4; largest_index=11, largest_value=4.
3. Blocked cell:
   - Stimulus: fired[44]=1 only, ships=5'b10000.
   - Required: density[44]=0, density[43]=5 (vertical placements only).
4. Boundary results:
   - Stimulus: ships=0, fired[0]=1.
   - Required: done after 101 cycles; all densities 0; largest_index=1, largest_value=0.
   - Stimulus: fired all ones, ships=5'h1F.
   - Required: largest_index=127, largest_value=0.
5. start while busy:
   - Stimulus: pulse start again 50 cycles into case 1.
   - Required: ignored; done timing and results identical to case 1.
6. Reset mid-sweep:
   - Stimulus: assert reset_n=0 300 cycles into case 1.
   - Required: done=1 and counters/largest_*=0 immediately, without waiting for a clock edge.
   - Follow-up: a fresh start then reproduces case 1 exactly.
